// File: rtl/action_reset_pkg.sv
// Shared reset-responder definitions: FSM state encoding used by the responder
// and by the reset sequencer bench.
package action_reset_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT    = 2'd0,
    ST_RELEASE   = 2'd1,
    ST_WAIT_IDLE = 2'd2,
    ST_READY     = 2'd3
  } reset_state_e;

  // Width needed to count from 0 up to and including n.
  function automatic int index_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/action_reset_sync.sv
// Two-stage synchronizer for the domain reset request; both stages reset to 1
// so the domain is held in reset until a clean low has crossed.
module action_reset_sync (
  input  logic clk,
  input  logic rstN,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/action_domain_reset_responder.sv
// Domain reset responder: holds local resets, releases them in index order, then
// acknowledges once all sub-blocks are idle. ACTION_RESET_INPUT_SYNC_EN adds an input synchronizer.
module action_domain_reset_responder
  import action_reset_pkg::*;
#(
  parameter int HoldCycles      = 8,
  parameter int HoldCounterSize = 4,
  parameter int LocalResets     = 2
) (
  input  logic                   clk,
  input  logic                   rstN,
  input  logic                   domainRst,
  output logic                   domainRdy,
  output logic [LocalResets-1:0] localRst,
  input  logic [LocalResets-1:0] localIdle
);

  localparam int IdxW = index_width(LocalResets);
  localparam logic [HoldCounterSize-1:0] HoldInit = HoldCounterSize'(HoldCycles);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(LocalResets - 1);

  logic rst_req;

`ifdef ACTION_RESET_INPUT_SYNC_EN
  action_reset_sync u_sync (
    .clk  (clk),
    .rstN (rstN),
    .d    (domainRst),
    .q    (rst_req)
  );
`else
  assign rst_req = domainRst;
`endif

  reset_state_e               state_q, state_d;
  logic [HoldCounterSize-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0]            idx_q, idx_d;
  logic [LocalResets-1:0]     local_rst_q, local_rst_d;
  logic                       rdy_q, rdy_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    local_rst_d = local_rst_q;
    rdy_d       = rdy_q;

    if (rst_req) begin
      state_d     = ST_ASSERT;
      cnt_d       = HoldInit;
      idx_d       = '0;
      local_rst_d = '1;
      rdy_d       = 1'b0;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          local_rst_d = '1;
          rdy_d       = 1'b0;
          if (cnt_q == '0) begin
            local_rst_d[0] = 1'b0;
            idx_d          = IdxW'(1);
            state_d        = (LocalResets == 1) ? ST_WAIT_IDLE : ST_RELEASE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end

        ST_RELEASE: begin
          rdy_d = 1'b0;
          for (int i = 0; i < LocalResets; i++) begin
            if (idx_q == IdxW'(i)) local_rst_d[i] = 1'b0;
          end
          idx_d = idx_q + 1'b1;
          if (idx_q == LastIdx) state_d = ST_WAIT_IDLE;
        end

        ST_WAIT_IDLE: begin
          rdy_d       = 1'b0;
          local_rst_d = '0;
          if (&localIdle) begin
            state_d = ST_READY;
            rdy_d   = 1'b1;
          end
        end

        ST_READY: begin
          rdy_d       = 1'b1;
          local_rst_d = '0;
        end

        default: begin
          state_d     = ST_ASSERT;
          cnt_d       = HoldInit;
          idx_d       = '0;
          local_rst_d = '1;
          rdy_d       = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q     <= ST_ASSERT;
      cnt_q       <= HoldInit;
      idx_q       <= '0;
      local_rst_q <= '1;
      rdy_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      local_rst_q <= local_rst_d;
      rdy_q       <= rdy_d;
    end
  end

  assign domainRdy = rdy_q;
  assign localRst  = local_rst_q;

endmodule

// File: tb/tb_action_domain_reset_responder.sv
// Directed bench for action_domain_reset_responder: one two-reset instance (hold 3)
// and one single-reset instance (hold 0) driven from a shared clock and rstN.
module tb_action_domain_reset_responder;

`ifdef ACTION_RESET_INPUT_SYNC_EN
  localparam int SyncLat = 2;
`else
  localparam int SyncLat = 0;
`endif

  logic       clk = 1'b0;
  logic       rstN;
  logic       domainRstA, domainRstB;
  logic [1:0] localIdleA;
  logic [0:0] localIdleB;
  logic       domainRdyA, domainRdyB;
  logic [1:0] localRstA;
  logic [0:0] localRstB;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  action_domain_reset_responder #(
    .HoldCycles      (3),
    .HoldCounterSize (4),
    .LocalResets     (2)
  ) dutA (
    .clk       (clk),
    .rstN      (rstN),
    .domainRst (domainRstA),
    .domainRdy (domainRdyA),
    .localRst  (localRstA),
    .localIdle (localIdleA)
  );

  action_domain_reset_responder #(
    .HoldCycles      (0),
    .HoldCounterSize (4),
    .LocalResets     (1)
  ) dutB (
    .clk       (clk),
    .rstN      (rstN),
    .domainRst (domainRstB),
    .domainRdy (domainRdyB),
    .localRst  (localRstB),
    .localIdle (localIdleB)
  );

  task automatic applyStimulus(input logic dRstA, input logic [1:0] idleA,
                               input logic dRstB, input logic idleB);
    domainRstA = dRstA;
    localIdleA = idleA;
    domainRstB = dRstB;
    localIdleB = idleB;
  endtask

  task automatic checkOutput(input string tag, input logic [1:0] observed,
                             input logic [1:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic tickN(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rstN = 1'b0;
    applyStimulus(1'b1, 2'b11, 1'b1, 1'b1);
    #12;
    checkOutput("rst_localRstA", localRstA, 2'b11);
    checkOutput("rst_rdyA", domainRdyA, 1'b0);
    checkOutput("rst_localRstB", localRstB, 1'b1);
    checkOutput("rst_rdyB", domainRdyB, 1'b0);

    // rstN release alone must not start the release sequence
    #4 rstN = 1'b1;
    tickN(4);
    checkOutput("hold_localRstA", localRstA, 2'b11);
    checkOutput("hold_rdyA", domainRdyA, 1'b0);
    checkOutput("hold_localRstB", localRstB, 1'b1);

    // Hold 3, two resets, already idle: release at 4 and 5, ready at 6
    applyStimulus(1'b0, 2'b11, 1'b1, 1'b1);
    tickN(3 + SyncLat);
    checkOutput("seq_e3_localRst", localRstA, 2'b11);
    tickN(1);
    checkOutput("seq_e4_localRst", localRstA, 2'b10);
    checkOutput("seq_e4_rdy", domainRdyA, 1'b0);
    tickN(1);
    checkOutput("seq_e5_localRst", localRstA, 2'b00);
    checkOutput("seq_e5_rdy", domainRdyA, 1'b0);
    tickN(1);
    checkOutput("seq_e6_rdy", domainRdyA, 1'b1);

    // Not all idle until edge 10: ready only at edge 11
    applyStimulus(1'b1, 2'b01, 1'b1, 1'b1);
    tickN(1 + SyncLat);
    checkOutput("idle_reassert_localRst", localRstA, 2'b11);
    checkOutput("idle_reassert_rdy", domainRdyA, 1'b0);
    applyStimulus(1'b0, 2'b01, 1'b1, 1'b1);
    tickN(6 + SyncLat);
    checkOutput("idle_e6_localRst", localRstA, 2'b00);
    checkOutput("idle_e6_rdy", domainRdyA, 1'b0);
    tickN(4);
    checkOutput("idle_e10_rdy", domainRdyA, 1'b0);
    applyStimulus(1'b0, 2'b11, 1'b1, 1'b1);
    tickN(1);
    checkOutput("idle_e11_rdy", domainRdyA, 1'b1);
    applyStimulus(1'b0, 2'b00, 1'b1, 1'b1);
    tickN(2);
    checkOutput("ready_idle_drop_rdy", domainRdyA, 1'b1);
    checkOutput("ready_idle_drop_localRst", localRstA, 2'b00);

    // Pulse at edge 5 restarts the full sequence with counter 3
    applyStimulus(1'b1, 2'b11, 1'b1, 1'b1);
    tickN(1 + SyncLat);
    checkOutput("pulse_pre_localRst", localRstA, 2'b11);
    for (int e = 1; e <= 11 + SyncLat; e++) begin
      applyStimulus(e == 5, 2'b11, 1'b1, 1'b1);
      tickN(1);
      if (e == 4 + SyncLat) checkOutput("pulse_e4_localRst", localRstA, 2'b10);
      if (e == 5 + SyncLat) begin
        checkOutput("pulse_e5_localRst", localRstA, 2'b11);
        checkOutput("pulse_e5_rdy", domainRdyA, 1'b0);
      end
      if (e == 8 + SyncLat) checkOutput("pulse_e8_localRst", localRstA, 2'b11);
      if (e == 9 + SyncLat) checkOutput("pulse_e9_localRst", localRstA, 2'b10);
      if (e == 10 + SyncLat) begin
        checkOutput("pulse_e10_localRst", localRstA, 2'b00);
        checkOutput("pulse_e10_rdy", domainRdyA, 1'b0);
      end
      if (e == 11 + SyncLat) checkOutput("pulse_e11_rdy", domainRdyA, 1'b1);
    end

    // Hold 0, single reset: localRst low at edge 1, ready at edge 2
    applyStimulus(1'b1, 2'b11, 1'b0, 1'b1);
    tickN(SyncLat);
    checkOutput("h0_pre_localRst", localRstB, 1'b1);
    tickN(1);
    checkOutput("h0_e1_localRst", localRstB, 1'b0);
    checkOutput("h0_e1_rdy", domainRdyB, 1'b0);
    tickN(1);
    checkOutput("h0_e2_rdy", domainRdyB, 1'b1);

    // rstN mid-RELEASE forces reset values without a clock edge
    applyStimulus(1'b0, 2'b11, 1'b0, 1'b1);
    tickN(4 + SyncLat);
    checkOutput("midrel_localRst", localRstA, 2'b10);
    #2 rstN = 1'b0;
    #1;
    checkOutput("async_localRstA", localRstA, 2'b11);
    checkOutput("async_rdyA", domainRdyA, 1'b0);
    checkOutput("async_localRstB", localRstB, 1'b1);
    checkOutput("async_rdyB", domainRdyB, 1'b0);
    applyStimulus(1'b1, 2'b11, 1'b1, 1'b1);
    #2 rstN = 1'b1;
    tickN(3);
    checkOutput("post_rst_localRstA", localRstA, 2'b11);
    checkOutput("post_rst_rdyA", domainRdyA, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/action_domain_reset_responder.md
ACTION_DOMAIN_RESET_RESPONDER -- requirements
Module: action_domain_reset_responder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter HoldCycles, default 8, SHALL set the minimum number of clocks local resets stay asserted after domainRst is sampled low.
REQ-003 Parameter HoldCounterSize, default 4, SHALL set the hold counter width; HoldCycles SHALL be less than 2**HoldCounterSize.
REQ-004 Parameter LocalResets, default 2, SHALL set the number of local reset/idle line pairs (minimum 1).
REQ-005 clk  input  1  clock.
REQ-006 rstN  input  1  asynchronous active-low reset.
REQ-007 domainRst  input  1  domain reset request from the reset sequencer; high = hold domain in reset.
REQ-008 domainRdy  output  1  domain ready acknowledge to the reset sequencer; high = domain out of reset and idle.
REQ-009 localRst  output  LocalResets  per-sub-block reset, active high, index 0 released first.
REQ-010 localIdle  input  LocalResets  per-sub-block idle/quiesced indication.

Function
REQ-011 The FSM SHALL have states ASSERT, RELEASE, WAIT_IDLE, READY.
REQ-012 ASSERT: all localRst high, domainRdy low; hold counter loaded with HoldCycles while domainRst is sampled high, decremented each clock while domainRst is sampled low.
REQ-013 ASSERT with counter == 0 and domainRst low SHALL, on the same edge, clear localRst[0], set release index to 1, and go to RELEASE (or WAIT_IDLE if LocalResets == 1).
REQ-014 RELEASE SHALL clear localRst[index] on each clock and increment index; after clearing localRst[LocalResets-1] it SHALL go to WAIT_IDLE.
REQ-015 WAIT_IDLE SHALL go to READY on the first edge where all localIdle bits are sampled high; it SHALL wait indefinitely otherwise.
REQ-016 READY SHALL drive domainRdy high and all localRst low; deassertion of localIdle in READY SHALL NOT affect domainRdy.
REQ-017 domainRst sampled high in any state SHALL, on that edge, set all localRst high, clear domainRdy, reload the counter and enter ASSERT.
REQ-018 With HoldCycles = 0, ASSERT SHALL exit on the first edge domainRst is sampled low.
REQ-019 Total latency from first low sample of domainRst to domainRdy high SHALL be HoldCycles + LocalResets + 1 clocks when localIdle is already all high.
REQ-020 All outputs SHALL be driven directly from registers.

Reset
REQ-021 rstN low SHALL asynchronously force state ASSERT, localRst all high, domainRdy low, counter = HoldCycles, index = 0.
REQ-022 rstN deassertion SHALL NOT itself start release; release depends only on domainRst sampling low.

Configuration
REQ-023 With ACTION_RESET_INPUT_SYNC_EN defined, domainRst SHALL pass through a two-stage synchronizer (reset to 1 by rstN) before the FSM, adding 2 clocks to every latency in REQ-017 and REQ-019.
REQ-024 Without ACTION_RESET_INPUT_SYNC_EN, domainRst SHALL feed the FSM directly with no added latency.

Structure
REQ-025 FSM state encodings SHALL live in shared package action_reset_pkg, also used by the reset sequencer bench.
REQ-026 The synchronizer SHALL be sub-module action_reset_sync, instantiated only under ACTION_RESET_INPUT_SYNC_EN.

Verification
REQ-027 rstN low, then released with domainRst high -> localRst = 2'b11, domainRdy = 0 indefinitely.
REQ-028 HoldCycles=3, LocalResets=2, localIdle=2'b11, domainRst falls before edge 1 -> localRst[0] low at edge 4, localRst[1] low at edge 5, domainRdy high at edge 6.
REQ-029 Same as REQ-028 but localIdle=2'b01 until edge 10 -> domainRdy rises at edge 11 only.
REQ-030 domainRst pulsed high at edge 5 of REQ-028 sequence -> localRst = 2'b11 at edge 5, domainRdy stays low, full sequence restarts with counter = 3.
REQ-031 HoldCycles=0, LocalResets=1, localIdle=1 -> localRst low at edge 1, domainRdy high at edge 2; with ACTION_RESET_INPUT_SYNC_EN, edges 3 and 4.
REQ-032 rstN asserted mid-RELEASE -> localRst = all ones and domainRdy = 0 immediately, without a clock edge.
